// File: rtl/jtag_b2p_pkg.sv
// Shared framing constants and decoder state for the JTAG master
// bytes<->packets path (encoder and decoder).
package jtag_b2p_pkg;

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ESC      = 2'd1,
    CHAN     = 2'd2,
    CHAN_ESC = 2'd3
  } b2p_state_t;

endpackage

// File: rtl/jtag_b2p_out_stage.sv
// Registered Avalon-ST output stage for the b2p decoder.
// Holds all outputs stable while stalled.
module jtag_b2p_out_stage
  import jtag_b2p_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [7:0]               data,
  input  logic                     sop,
  input  logic                     eop,
  input  logic [CHANNEL_WIDTH-1:0] channel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel
);

  // load a new beat, or retire the current one once taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_data          <= data;
      out_startofpacket <= sop;
      out_endofpacket   <= eop;
      out_channel       <= channel;
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end
  end

endmodule

// File: rtl/jtag_master_b2p_decoder.sv
// Bytes-to-packets decoder: strips SOP/EOP/CHANNEL/ESCAPE framing.
// Channel decoding is enabled by defining B2P_CHANNEL_DECODE_EN.
module jtag_master_b2p_decoder
  import jtag_b2p_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel
);

  b2p_state_t state, state_nxt;
  logic       pend_sop, pend_eop;
  logic       set_sop, set_eop;
  logic       emit, accept;
  logic [7:0] dec;
  logic       chan_ld;
  logic [CHANNEL_WIDTH-1:0] chan_out;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // decode one accepted byte against the current framing state
  always_comb begin
    state_nxt = state;
    set_sop   = 1'b0;
    set_eop   = 1'b0;
    emit      = 1'b0;
    chan_ld   = 1'b0;
    dec       = in_data;
    unique case (state)
      NORMAL: begin
        unique case (1'b1)
          (in_data == SOP_CHAR):  set_sop   = 1'b1;
          (in_data == EOP_CHAR):  set_eop   = 1'b1;
          (in_data == CHAN_CHAR): state_nxt = CHAN;
          (in_data == ESC_CHAR):  state_nxt = ESC;
          default:                emit      = 1'b1;
        endcase
      end
      ESC: begin
        dec       = in_data ^ ESC_XOR;
        emit      = 1'b1;
        state_nxt = NORMAL;
      end
      CHAN: begin
        if (in_data == ESC_CHAR) begin
          state_nxt = CHAN_ESC;
        end else begin
          chan_ld   = 1'b1;
          state_nxt = NORMAL;
        end
      end
      CHAN_ESC: begin
        dec       = in_data ^ ESC_XOR;
        chan_ld   = 1'b1;
        state_nxt = NORMAL;
      end
    endcase
  end

  // framing state and pending packet flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NORMAL;
      pend_sop <= 1'b0;
      pend_eop <= 1'b0;
    end else if (accept) begin
      state    <= state_nxt;
      pend_sop <= emit ? 1'b0 : (pend_sop | set_sop);
      pend_eop <= emit ? 1'b0 : (pend_eop | set_eop);
    end
  end

`ifdef B2P_CHANNEL_DECODE_EN
  logic [CHANNEL_WIDTH-1:0] chan_reg;

  // channel register, sticky until the next CHANNEL marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_reg <= '0;
    end else if (accept && chan_ld) begin
      chan_reg <= dec[CHANNEL_WIDTH-1:0];
    end
  end

  assign chan_out = chan_reg;
`else
  logic unused_chan;
  assign unused_chan = chan_ld;
  assign chan_out    = '0;
`endif

  jtag_b2p_out_stage #(
    .CHANNEL_WIDTH(CHANNEL_WIDTH)
  ) u_out_stage (
    .clk              (clk),
    .rst              (reset),
    .load             (accept && emit),
    .data             (dec),
    .sop              (pend_sop),
    .eop              (pend_eop),
    .channel          (chan_out),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .out_channel      (out_channel)
  );

endmodule
